// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply/divide beside the execute-stage ALU.
// Owns the architectural HI/LO registers. MULTU/DIVU take WIDTH cycles, and
// stall holds dependent ops issued while an operation is in progress.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no operation in flight; MFHI/MFLO read HI/LO with no delay
// ST_MUL  | shift-add multiply, one multiplier bit per cycle, LSB first
// ST_DIV  | restoring divide, one quotient bit per cycle, MSB first
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] OP_MULTU = 4'd7;
    localparam logic [3:0] OP_DIVU  = 4'd8;
    localparam logic [3:0] OP_MFHI  = 4'd9;
    localparam logic [3:0] OP_MFLO  = 4'd10;
    localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // acc: upper product half (MUL) or partial remainder (DIV).
    // quo: multiplier shifting out / lower product half (MUL), or
    //      dividend shifting out / quotient shifting in (DIV).
    // opb: multiplicand (MUL) or divisor (DIV).
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] opb;
    logic [5:0]       cnt;

    logic start_mul;
    logic start_div;
    logic finish;
    logic last_iter;
    logic md_code;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc_nx;
    logic [WIDTH-1:0] mul_quo_nx;

    logic [WIDTH:0]   rem_sh;
    logic             div_ok;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] div_acc_nx;
    logic [WIDTH-1:0] div_quo_nx;

    assign last_iter = (cnt == CNT_LAST);
    assign busy      = (state_q != ST_IDLE);
    assign md_code   = (alu_ctrl == OP_MULTU) || (alu_ctrl == OP_DIVU) ||
                       (alu_ctrl == OP_MFHI)  || (alu_ctrl == OP_MFLO);
    assign stall     = busy && op_valid && md_code;

    // HI/LO read port; MFHI/MFLO see the registers directly.
    always_comb begin
        result = '0;
        if (alu_ctrl == OP_MFHI) begin
            result = hi;
        end else if (alu_ctrl == OP_MFLO) begin
            result = lo;
        end
    end

    // State register; an asynchronous reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: starts only from IDLE, completes on the last iteration.
    always_comb begin
        state_d   = state_q;
        start_mul = 1'b0;
        start_div = 1'b0;
        finish    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_valid && (alu_ctrl == OP_MULTU)) begin
                    state_d   = ST_MUL;
                    start_mul = 1'b1;
                end else if (op_valid && (alu_ctrl == OP_DIVU)) begin
                    state_d   = ST_DIV;
                    start_div = 1'b1;
                end
            end
            ST_MUL, ST_DIV: begin
                if (last_iter) begin
                    state_d = ST_IDLE;
                    finish  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // One multiply step: conditional add into the upper half, then shift
    // the whole product right with the carry entering at the top.
    always_comb begin
        mul_sum    = {1'b0, acc} + (quo[0] ? {1'b0, opb} : '0);
        mul_acc_nx = mul_sum[WIDTH:1];
        mul_quo_nx = {mul_sum[0], quo[WIDTH-1:1]};
    end

    // One restoring-divide step. The shifted remainder needs WIDTH+1 bits;
    // when it is >= the divisor the difference always fits in WIDTH bits.
    // A zero divisor always "subtracts", giving all-ones quotient and the
    // dividend as remainder.
    always_comb begin
        rem_sh     = {acc, quo[WIDTH-1]};
        div_ok     = (rem_sh >= {1'b0, opb});
        div_diff   = rem_sh[WIDTH-1:0] - opb;
        div_acc_nx = div_ok ? div_diff : rem_sh[WIDTH-1:0];
        div_quo_nx = {quo[WIDTH-2:0], div_ok};
    end

    // Working registers, iteration counter, HI/LO and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            quo  <= '0;
            opb  <= '0;
            cnt  <= '0;
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= finish;
            if (start_mul) begin
                acc <= '0;
                quo <= b;
                opb <= a;
                cnt <= '0;
            end else if (start_div) begin
                acc <= '0;
                quo <= a;
                opb <= b;
                cnt <= '0;
            end else if (state_q == ST_MUL) begin
                acc <= mul_acc_nx;
                quo <= mul_quo_nx;
                cnt <= cnt + 6'd1;
                if (finish) begin
                    hi <= mul_acc_nx;
                    lo <= mul_quo_nx;
                end
            end else if (state_q == ST_DIV) begin
                acc <= div_acc_nx;
                quo <= div_quo_nx;
                cnt <= cnt + 6'd1;
                if (finish) begin
                    hi <= div_acc_nx;
                    lo <= div_quo_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed products/quotients, stall
// behaviour, mid-operation reset and back-to-back issue.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic [3:0]  alu_ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors    = 0;
    int miscompares = 0;
    int cycles;
    int bad;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .alu_ctrl (alu_ctrl),
        .a        (a),
        .b        (b),
        .result   (result),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an op for one edge, then return the bus to idle.
    task automatic issue(input logic [3:0] code, input logic [31:0] va, input logic [31:0] vb);
        op_valid = 1'b1;
        alu_ctrl = code;
        a        = va;
        b        = vb;
        tick();
        op_valid = 1'b0;
        alu_ctrl = 4'd0;
        #1;
    endtask

    // Tick while busy; cycles ends as the number of busy cycles.
    task automatic run_busy();
        cycles = 0;
        bad    = 0;
        while (busy && cycles < 100) begin
            if (op_valid && !stall) bad++;
            tick();
            #1;
            cycles++;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        op_valid = 1'b0;
        alu_ctrl = 4'd0;
        a        = '0;
        b        = '0;
        #12;
        // Reset state, including a read attempt while idle.
        op_valid = 1'b1;
        alu_ctrl = 4'd9;
        #1;
        chk("rst_busy",   {31'd0, busy},  32'd0);
        chk("rst_done",   {31'd0, done},  32'd0);
        chk("rst_hi",     hi,             32'd0);
        chk("rst_lo",     lo,             32'd0);
        chk("rst_stall",  {31'd0, stall}, 32'd0);
        chk("rst_result", result,         32'd0);
        op_valid = 1'b0;
        alu_ctrl = 4'd0;
        rst_n    = 1'b1;
        tick();

        // MULTU max x max.
        issue(4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("m1_busy_start", {31'd0, busy}, 32'd1);
        run_busy();
        chk("m1_cycles", cycles, 32'd32);
        chk("m1_done",   {31'd0, done}, 32'd1);
        chk("m1_hi",     hi, 32'hFFFF_FFFE);
        chk("m1_lo",     lo, 32'h0000_0001);
        tick();
        chk("m1_done_drop", {31'd0, done}, 32'd0);

        // DIVU 100/7, then MULTU 3x5; HI/LO hold during the multiply.
        issue(4'd8, 32'd100, 32'd7);
        chk("d1_hi_hold", hi, 32'hFFFF_FFFE);
        run_busy();
        chk("d1_cycles", cycles, 32'd32);
        chk("d1_lo", lo, 32'd14);
        chk("d1_hi", hi, 32'd2);
        issue(4'd7, 32'd3, 32'd5);
        chk("m2_lo_hold", lo, 32'd14);
        run_busy();
        chk("m2_hi", hi, 32'd0);
        chk("m2_lo", lo, 32'd15);

        // Divide by zero: all-ones quotient, dividend as remainder, one done.
        issue(4'd8, 32'h0000_1234, 32'd0);
        run_busy();
        chk("dz_cycles", cycles, 32'd32);
        chk("dz_lo",   lo, 32'hFFFF_FFFF);
        chk("dz_hi",   hi, 32'h0000_1234);
        chk("dz_done", {31'd0, done}, 32'd1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) bad++;
        end
        chk("dz_single_pulse", bad, 32'd0);

        // MFHI held behind a MULTU 6x7; an ADD code never stalls.
        issue(4'd7, 32'd6, 32'd7);
        op_valid = 1'b1;
        alu_ctrl = 4'd2;
        #1;
        chk("add_no_stall", {31'd0, stall}, 32'd0);
        alu_ctrl = 4'd9;
        #1;
        chk("mfhi_stall", {31'd0, stall}, 32'd1);
        run_busy();
        chk("mfhi_stall_cycles", bad, 32'd0);
        chk("mfhi_wait_cycles", cycles, 32'd32);
        chk("mfhi_released", {31'd0, stall}, 32'd0);
        chk("mfhi_result", result, 32'd0);
        alu_ctrl = 4'd10;
        #1;
        chk("mflo_result", result, 32'd42);
        op_valid = 1'b0;
        alu_ctrl = 4'd0;
        tick();

        // Reset ten iterations into a DIVU: immediate clear, no done pulse.
        issue(4'd8, 32'd1000, 32'd3);
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_hi",   hi, 32'd0);
        chk("ar_lo",   lo, 32'd0);
        #2;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) bad++;
        end
        chk("ar_no_done", bad, 32'd0);
        issue(4'd7, 32'd2, 32'd2);
        run_busy();
        chk("ar_m_lo", lo, 32'd4);
        chk("ar_m_hi", hi, 32'd0);

        // Back-to-back MULTU: second is held until the first completes.
        issue(4'd7, 32'h0001_0000, 32'h0003_0000);
        op_valid = 1'b1;
        alu_ctrl = 4'd7;
        a        = 32'd5;
        b        = 32'd9;
        #1;
        run_busy();
        chk("bb_first_cycles", cycles, 32'd32);
        chk("bb_stall_while_busy", bad, 32'd0);
        chk("bb_accept_stall", {31'd0, stall}, 32'd0);
        chk("bb_first_hi", hi, 32'd3);
        chk("bb_first_lo", lo, 32'd0);
        tick();
        op_valid = 1'b0;
        alu_ctrl = 4'd0;
        #1;
        chk("bb_second_busy", {31'd0, busy}, 32'd1);
        chk("bb_hi_visible", hi, 32'd3);
        run_busy();
        chk("bb_second_cycles", cycles, 32'd32);
        chk("bb_second_hi", hi, 32'd0);
        chk("bb_second_lo", lo, 32'd45);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
